// File: rtl/alu_mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// alu_mem_lsu_pkg
// Shared types for the load/store unit of the simple processor.
//   func_t      : execute-stage operation code; only LOAD and STORE reach memory
//   mem_size_t  : access size (BYTE/HALF/WORD/DOUBLE)
//   lsu_state_t : load/store unit state machine encoding
//   LSU_TMO_W   : minimum width of the memory timeout counter
// ---------------------------------------------------------------------------
package alu_mem_lsu_pkg;

  // Default datapath width of the processor.
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Operation codes coming from the execute stage. The ALU codes are listed so
  // that the unit can recognise and reject them.
  typedef enum logic [3:0] {
    FUNC_ADD = 4'd0,
    FUNC_SUB = 4'd1,
    FUNC_AND = 4'd2,
    FUNC_OR  = 4'd3,
    FUNC_XOR = 4'd4,
    FUNC_SLL = 4'd5,
    FUNC_SRL = 4'd6,
    FUNC_SRA = 4'd7,
    FUNC_SLT = 4'd8,
    LOAD     = 4'd9,
    STORE    = 4'd10
  } func_t;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_t;

  // Largest timeout the counter is sized for by default; one spare bit keeps
  // the counter from wrapping in the cycle it reaches the limit.
  localparam int LSU_TIMEOUT_MAX = 255;
  localparam int LSU_TMO_W       = $clog2(LSU_TIMEOUT_MAX) + 1;

  // An access is aligned when the address is a multiple of its size.
  function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      HALF:    mis = addr_lo[0];
      WORD:    mis = |addr_lo[1:0];
      DOUBLE:  mis = |addr_lo[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/alu_mem_lane_align.sv
// ---------------------------------------------------------------------------
// alu_mem_lane_align
// Purely combinational lane steering for the load/store unit.
//   size       : access size
//   offset     : byte offset of the access within the memory word
//   sign_ext   : 1 = sign-extend loads, 0 = zero-extend
//   store_data : right-aligned store data
//   load_word  : full word returned by memory
//   be         : byte enables for the access
//   wdata      : store data replicated across every lane
//   load_data  : extracted and extended load result
// ---------------------------------------------------------------------------
module alu_mem_lane_align
  import alu_mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int NB    = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  mem_size_t             size,
  input  logic [OFF_W-1:0]      offset,
  input  logic                  sign_ext,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] load_word,
  output logic [NB-1:0]         be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [NB-1:0]         lane_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic                  msb;

  // Byte enables are a run of 'bytes' ones shifted up to the access offset.
  // Store data is replicated so the addressed lane carries it whatever the
  // offset, which means the memory only has to honour the byte enables.
  always_comb begin
    lane_mask = '0;
    wdata     = store_data;
    case (size)
      BYTE: begin
        lane_mask = NB'(1);
        wdata     = {NB{store_data[7:0]}};
      end
      HALF: begin
        lane_mask = NB'(2'b11);
        wdata     = {(NB/2){store_data[15:0]}};
      end
      WORD: begin
        lane_mask = NB'(4'hF);
        wdata     = {(NB/4){store_data[31:0]}};
      end
      default: begin
        lane_mask = '1;
        wdata     = store_data;
      end
    endcase
    be = lane_mask << offset;
  end

  // Loads bring the addressed lane down to bit 0, keep only the access width
  // and fill the upper bits with the lane's top bit when sign-extending.
  // Masks are used instead of part-selects so a full-width WORD on a 32-bit
  // datapath needs no empty range.
  always_comb begin
    shifted = load_word >> {offset, 3'b000};
    keep    = '1;
    msb     = 1'b0;
    case (size)
      BYTE: begin
        keep = DATA_WIDTH'(8'hFF);
        msb  = shifted[7];
      end
      HALF: begin
        keep = DATA_WIDTH'(16'hFFFF);
        msb  = shifted[15];
      end
      WORD: begin
        keep = DATA_WIDTH'(32'hFFFF_FFFF);
        msb  = shifted[31];
      end
      default: begin
        keep = '1;
        msb  = 1'b0;
      end
    endcase
    load_data = (shifted & keep) | ((sign_ext && msb) ? ~keep : '0);
  end

endmodule

// File: rtl/alu_mem_lsu.sv
// ---------------------------------------------------------------------------
// alu_mem_lsu
// Load/store unit between the execute stage and the data-memory port.
//   clk_i, arst_ni                : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       : operation handshake (ready only in IDLE)
//   func_i, size_i, sign_ext_i    : operation, access size, load extension
//   rs1_data_i, rs2_data_i        : byte address, right-aligned store data
//   rsp_valid_o/rsp_ready_i       : response handshake
//   rd_data_o, err_o              : load result / error flag
//   mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o : memory request
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i                    : memory reply
// ---------------------------------------------------------------------------
module alu_mem_lsu
  import alu_mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int NB    = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  func_t                 func_i,
  input  mem_size_t             size_i,
  input  logic                  sign_ext_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [NB-1:0]         mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  // The counter must hold TIMEOUT_CYCLES+1 without wrapping.
  localparam int CNT_NEED = $clog2(TIMEOUT_CYCLES + 2);
  localparam int CNT_W    = (CNT_NEED > LSU_TMO_W) ? CNT_NEED : LSU_TMO_W;

  lsu_state_t            state_q, state_d;
  func_t                 func_q;
  mem_size_t             size_q;
  logic                  sign_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [OFF_W-1:0]      off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  err_q;

  logic                  illegal;
  logic                  timeout_hit;
  logic                  in_req;
  logic [NB-1:0]         lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] load_data;

  // Address bits above ADDR_WIDTH are deliberately dropped.
  if (DATA_WIDTH > ADDR_WIDTH) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^rs1_data_i[DATA_WIDTH-1:ADDR_WIDTH];
  end

  // An offered operation is rejected without touching memory when it is not a
  // memory op, asks for DOUBLE on a 32-bit datapath, or is misaligned.
  always_comb begin
    illegal = 1'b0;
    if ((func_i != LOAD) && (func_i != STORE)) illegal = 1'b1;
    if ((size_i == DOUBLE) && (DATA_WIDTH == 32)) illegal = 1'b1;
    if (is_misaligned(size_i, rs1_data_i[2:0])) illegal = 1'b1;
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // State register; reset returns to IDLE immediately, which also drops
  // mem_req_o because it is decoded from the state.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= LSU_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic. A grant or read-valid arriving in the same cycle the
  // counter reaches the limit wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid_i) state_d = illegal ? LSU_RESP : LSU_REQ;
      end
      LSU_REQ: begin
        if (mem_gnt_i)        state_d = (func_q == STORE) ? LSU_RESP : LSU_WAIT;
        else if (timeout_hit) state_d = LSU_RESP;
      end
      LSU_WAIT: begin
        if (mem_rvalid_i)     state_d = LSU_RESP;
        else if (timeout_hit) state_d = LSU_RESP;
      end
      LSU_RESP: begin
        if (rsp_ready_i) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Operation latches, timeout counter and response registers. The response
  // is built on the way into RESP so rd_data_o/err_o come straight from flops
  // and stay put until the consumer takes them. rvalid outside WAIT is simply
  // never looked at.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      func_q    <= FUNC_ADD;
      size_q    <= BYTE;
      sign_q    <= 1'b0;
      addr_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (req_valid_i) begin
            func_q    <= func_i;
            size_q    <= size_i;
            sign_q    <= sign_ext_i;
            addr_q    <= rs1_data_i[ADDR_WIDTH-1:0];
            off_q     <= rs1_data_i[OFF_W-1:0];
            wdata_q   <= rs2_data_i;
            cnt_q     <= '0;
            rd_data_q <= '0;
            err_q     <= illegal;
          end
        end
        LSU_REQ: begin
          if (mem_gnt_i) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        LSU_WAIT: begin
          if (mem_rvalid_i) begin
            rd_data_q <= load_data;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        LSU_RESP: begin
          if (rsp_ready_i) begin
            rd_data_q <= '0;
            err_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  alu_mem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_align (
    .size      (size_q),
    .offset    (off_q),
    .sign_ext  (sign_q),
    .store_data(wdata_q),
    .load_word (mem_rdata_i),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (load_data)
  );

  // Memory-side outputs are only non-zero while requesting; everything is a
  // function of state and latched registers.
  assign in_req      = (state_q == LSU_REQ);
  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req && (func_q == STORE);
  assign mem_addr_o  = in_req ? {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)} : '0;
  assign mem_be_o    = in_req ? lane_be : '0;
  assign mem_wdata_o = in_req ? lane_wdata : '0;

  assign req_ready_o = (state_q == LSU_IDLE);
  assign rsp_valid_o = (state_q == LSU_RESP);
  assign rd_data_o   = rd_data_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_alu_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_alu_mem_lsu
// Directed bench for alu_mem_lsu: a 32-bit instance with a short timeout and
// a 64-bit instance for DOUBLE and wide-lane cases.
// ---------------------------------------------------------------------------
module tb_alu_mem_lsu;
  import alu_mem_lsu_pkg::*;

  logic clk;
  logic arst_n;

  // 32-bit instance signals
  logic        req_valid, req_ready, sign_ext, rsp_valid, rsp_ready, err;
  func_t       func;
  mem_size_t   size;
  logic [31:0] rs1, rs2, rd_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;

  // 64-bit instance signals
  logic        w_req_valid, w_req_ready, w_sign_ext, w_rsp_valid, w_rsp_ready, w_err;
  func_t       w_func;
  mem_size_t   w_size;
  logic [63:0] w_rs1, w_rs2, w_rd_data, w_mem_wdata, w_mem_rdata;
  logic [31:0] w_mem_addr;
  logic        w_mem_req, w_mem_we, w_mem_gnt, w_mem_rvalid;
  logic [7:0]  w_mem_be;

  int checks = 0;
  int errors = 0;

  alu_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_lsu32 (
    .clk_i(clk), .arst_ni(arst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .func_i(func), .size_i(size), .sign_ext_i(sign_ext),
    .rs1_data_i(rs1), .rs2_data_i(rs2),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rd_data_o(rd_data), .err_o(err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  alu_mem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_lsu64 (
    .clk_i(clk), .arst_ni(arst_n),
    .req_valid_i(w_req_valid), .req_ready_o(w_req_ready),
    .func_i(w_func), .size_i(w_size), .sign_ext_i(w_sign_ext),
    .rs1_data_i(w_rs1), .rs2_data_i(w_rs2),
    .rsp_valid_o(w_rsp_valid), .rsp_ready_i(w_rsp_ready),
    .rd_data_o(w_rd_data), .err_o(w_err),
    .mem_req_o(w_mem_req), .mem_we_o(w_mem_we), .mem_addr_o(w_mem_addr),
    .mem_be_o(w_mem_be), .mem_wdata_o(w_mem_wdata),
    .mem_gnt_i(w_mem_gnt), .mem_rvalid_i(w_mem_rvalid), .mem_rdata_i(w_mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one operation to the 32-bit unit and let it be accepted (cycle N).
  task automatic applyStimulus(input func_t f, input mem_size_t s, input logic sx,
                               input logic [31:0] a, input logic [31:0] d);
    func = f; size = s; sign_ext = sx; rs1 = a; rs2 = d; req_valid = 1'b1;
    checkOutput("accept_ready", {63'd0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("idle_after_rsp", {62'd0, req_ready, rsp_valid}, 64'b10);
  endtask

  // Load with immediate grant and rvalid one cycle later; the response is
  // then held for 'hold' cycles with rsp_ready low before being consumed.
  task automatic doLoad32(input string tag, input mem_size_t s, input logic sx,
                          input logic [31:0] a, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd, input int hold);
    applyStimulus(LOAD, s, sx, a, 32'h0);
    checkOutput({tag, "_req"},  {63'd0, mem_req}, 64'd1);
    checkOutput({tag, "_we"},   {63'd0, mem_we}, 64'd0);
    checkOutput({tag, "_addr"}, {32'd0, mem_addr}, {32'd0, exp_addr});
    checkOutput({tag, "_be"},   {60'd0, mem_be}, {60'd0, exp_be});
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checkOutput({tag, "_wait"}, {62'd0, mem_req, rsp_valid}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i <= hold; i++) begin
      checkOutput({tag, "_rsp"}, {61'd0, rsp_valid, err, req_ready}, 64'b100);
      checkOutput({tag, "_rd"},  {32'd0, rd_data}, {32'd0, exp_rd});
      if (i < hold) begin
        req_valid = 1'b1;
        step();
      end
    end
    req_valid = 1'b0;
    consume();
  endtask

  task automatic doLoad64(input string tag, input mem_size_t s, input logic sx,
                          input logic [63:0] a, input logic [63:0] rdata,
                          input logic [31:0] exp_addr, input logic [7:0] exp_be,
                          input logic [63:0] exp_rd);
    w_func = LOAD; w_size = s; w_sign_ext = sx; w_rs1 = a; w_rs2 = 64'h0; w_req_valid = 1'b1;
    step();
    w_req_valid = 1'b0;
    checkOutput({tag, "_req"},  {63'd0, w_mem_req}, 64'd1);
    checkOutput({tag, "_addr"}, {32'd0, w_mem_addr}, {32'd0, exp_addr});
    checkOutput({tag, "_be"},   {56'd0, w_mem_be}, {56'd0, exp_be});
    w_mem_gnt = 1'b1;
    step();
    w_mem_gnt = 1'b0;
    w_mem_rvalid = 1'b1; w_mem_rdata = rdata;
    step();
    w_mem_rvalid = 1'b0;
    checkOutput({tag, "_rsp"}, {62'd0, w_rsp_valid, w_err}, 64'b10);
    checkOutput({tag, "_rd"},  w_rd_data, exp_rd);
    w_rsp_ready = 1'b1;
    step();
    w_rsp_ready = 1'b0;
  endtask

  func_t       ill_f[3] = '{LOAD, LOAD, FUNC_ADD};
  mem_size_t   ill_s[3] = '{WORD, DOUBLE, WORD};
  logic [31:0] ill_a[3] = '{32'h6, 32'h8, 32'h10};

  initial begin
    arst_n = 1'b0;
    req_valid = 0; func = FUNC_ADD; size = BYTE; sign_ext = 0; rs1 = 0; rs2 = 0;
    rsp_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    w_req_valid = 0; w_func = FUNC_ADD; w_size = BYTE; w_sign_ext = 0; w_rs1 = 0; w_rs2 = 0;
    w_rsp_ready = 0; w_mem_gnt = 0; w_mem_rvalid = 0; w_mem_rdata = 0;

    // Reset state
    step();
    step();
    checkOutput("rst_ready",   {63'd0, req_ready}, 64'd1);
    checkOutput("rst_rsp",     {62'd0, rsp_valid, err}, 64'd0);
    checkOutput("rst_mem",     {62'd0, mem_req, mem_we}, 64'd0);
    checkOutput("rst_be",      {60'd0, mem_be}, 64'd0);
    checkOutput("rst_addr",    {32'd0, mem_addr}, 64'd0);
    checkOutput("rst_wdata",   {32'd0, mem_wdata}, 64'd0);
    checkOutput("rst_rd",      {32'd0, rd_data}, 64'd0);
    checkOutput("rst_ready64", {63'd0, w_req_ready}, 64'd1);
    arst_n = 1'b1;
    step();

    // LOAD HALF sign-extended from the upper half
    doLoad32("ld_half_s", HALF, 1'b1, 32'h1002, 32'h8001_0000, 32'h1000, 4'b1100, 32'hFFFF_8001, 0);

    // STORE BYTE, grant delayed three cycles
    applyStimulus(STORE, BYTE, 1'b0, 32'h23, 32'hAB);
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      checkOutput("st_b_req",   {61'd0, mem_req, mem_we, rsp_valid}, 64'b110);
      checkOutput("st_b_be",    {60'd0, mem_be}, 64'b1000);
      checkOutput("st_b_wdata", {32'd0, mem_wdata}, 64'hABAB_ABAB);
      checkOutput("st_b_addr",  {32'd0, mem_addr}, 64'h20);
      step();
    end
    mem_gnt = 1'b0;
    checkOutput("st_b_rsp", {61'd0, rsp_valid, err, mem_req}, 64'b100);
    checkOutput("st_b_rd",  {32'd0, rd_data}, 64'd0);
    consume();

    // Illegal operations respond at N+1 without a memory request
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ill_f[i], ill_s[i], 1'b0, ill_a[i], 32'h0);
      checkOutput("illegal_rsp", {61'd0, rsp_valid, err, mem_req}, 64'b110);
      checkOutput("illegal_rd",  {32'd0, rd_data}, 64'd0);
      consume();
    end

    // Timeout in REQ: five request cycles, then error and mem_req dropped
    applyStimulus(LOAD, WORD, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("tmo_req_held", {62'd0, mem_req, rsp_valid}, 64'b10);
      step();
    end
    checkOutput("tmo_req_rsp", {61'd0, rsp_valid, err, mem_req}, 64'b110);
    checkOutput("tmo_req_rd",  {32'd0, rd_data}, 64'd0);
    consume();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    step();
    checkOutput("stray_rvalid", {62'd0, rsp_valid, req_ready}, 64'b01);

    // Next operations complete normally: zero- and sign-extended bytes
    doLoad32("ld_byte_z", BYTE, 1'b0, 32'h41, 32'h0000_F500, 32'h40, 4'b0010, 32'h0000_00F5, 0);
    doLoad32("ld_byte_s", BYTE, 1'b1, 32'h43, 32'h8000_0000, 32'h40, 4'b1000, 32'hFFFF_FF80, 0);

    // Timeout in WAIT: grant given, rvalid never comes
    applyStimulus(LOAD, WORD, 1'b0, 32'h48, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("tmo_wait_held", {63'd0, rsp_valid}, 64'd0);
      step();
    end
    checkOutput("tmo_wait_rsp", {62'd0, rsp_valid, err}, 64'b11);
    consume();

    // Response back-pressure for five cycles
    doLoad32("ld_word_hold", WORD, 1'b0, 32'h44, 32'hDEAD_BEEF, 32'h44, 4'b1111, 32'hDEAD_BEEF, 5);

    // Reset while in REQ drops mem_req at once
    applyStimulus(LOAD, WORD, 1'b0, 32'h80, 32'h0);
    checkOutput("rst_req_pre", {63'd0, mem_req}, 64'd1);
    #2 arst_n = 1'b0;
    #1 checkOutput("rst_req_drop", {61'd0, mem_req, rsp_valid, req_ready}, 64'b001);
    #2 arst_n = 1'b1;
    step();

    // Reset while in WAIT; a late rvalid must not produce a response
    applyStimulus(LOAD, WORD, 1'b0, 32'h84, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checkOutput("rst_wait_pre", {62'd0, mem_req, req_ready}, 64'd0);
    #2 arst_n = 1'b0;
    #1 checkOutput("rst_wait_now", {61'd0, mem_req, rsp_valid, req_ready}, 64'b001);
    #2 arst_n = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    step();
    checkOutput("rst_late_rvalid", {62'd0, rsp_valid, req_ready}, 64'b01);

    // 64-bit datapath: DOUBLE passes through, WORD sign-extends from upper lane
    doLoad64("ld64_double", DOUBLE, 1'b0, 64'h8, 64'h0123_4567_89AB_CDEF, 32'h8, 8'hFF, 64'h0123_4567_89AB_CDEF);
    doLoad64("ld64_word_s", WORD, 1'b1, 64'h4, 64'h8000_0000_0000_0000, 32'h0, 8'hF0, 64'hFFFF_FFFF_8000_0000);

    // 64-bit STORE HALF in the top lane
    w_func = STORE; w_size = HALF; w_sign_ext = 0; w_rs1 = 64'h6; w_rs2 = 64'h1234_BEEF; w_req_valid = 1'b1;
    step();
    w_req_valid = 1'b0;
    checkOutput("st64_be",    {56'd0, w_mem_be}, 64'hC0);
    checkOutput("st64_wdata", w_mem_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    checkOutput("st64_we",    {62'd0, w_mem_req, w_mem_we}, 64'b11);
    w_mem_gnt = 1'b1;
    step();
    w_mem_gnt = 1'b0;
    checkOutput("st64_rsp", {62'd0, w_rsp_valid, w_err}, 64'b10);
    w_rsp_ready = 1'b1;
    step();
    w_rsp_ready = 1'b0;
    checkOutput("st64_idle", {63'd0, w_req_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
